rx_lane_deskew: RTL and testbench

- Multi-lane receive deskew stage for 8b/10b rates (Gen1/Gen2, 8-bit PIPE width).
- Sits between the per-lane descramblers and the lane-management/merge stage (LMC_RX).
- Uses the K28.5 COM symbol seen on every active lane to measure inter-lane skew, then delays early lanes so symbols leave column-aligned.
- Monitors alignment on each later COM column and re-acquires on loss.

---
 rtl/rx_lane_deskew_if.sv | 43 ++++
 rtl/rx_lane_deskew.sv | 184 ++++++++++++++++++
 tb/tb_rx_lane_deskew.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_lane_deskew_if.sv
// Deskew bus: per-lane descrambler symbols in, column-aligned symbols out.
// master drives descrambler*/numberOfDetectedLanes, slave drives deskew*.
//   descramblerData/K/Valid : lane i symbol at [8i+:8], K and valid at [i]
//   numberOfDetectedLanes   : active lane count, lanes 0..n-1
//   deskewData/K            : aligned symbols (inactive lanes 0)
//   deskewValid/Locked/Error: column valid, aligned state, error pulse
interface rx_lane_deskew_if #(
    parameter int LANES = 16
);
    logic [LANES*8-1:0] descramblerData;
    logic [LANES-1:0]   descramblerDataK;
    logic [LANES-1:0]   descramblerDataValid;
    logic [4:0]         numberOfDetectedLanes;
    logic [LANES*8-1:0] deskewData;
    logic [LANES-1:0]   deskewDataK;
    logic               deskewValid;
    logic               deskewLocked;
    logic               deskewError;

    modport master (
        output descramblerData,
        output descramblerDataK,
        output descramblerDataValid,
        output numberOfDetectedLanes,
        input  deskewData,
        input  deskewDataK,
        input  deskewValid,
        input  deskewLocked,
        input  deskewError
    );

    modport slave (
        input  descramblerData,
        input  descramblerDataK,
        input  descramblerDataValid,
        input  numberOfDetectedLanes,
        output deskewData,
        output deskewDataK,
        output deskewValid,
        output deskewLocked,
        output deskewError
    );
endinterface

// File: rtl/rx_lane_deskew.sv
// Multi-lane 8b/10b receive deskew: measures COM skew, delays early lanes.
// Ports: clk, reset (async active-low), bus (rx_lane_deskew_if.slave).
module rx_lane_deskew #(
    parameter int         LANES      = 16,
    parameter int         MAX_SKEW   = 4,
    parameter logic [7:0] COM_SYMBOL = 8'hBC
) (
    input logic             clk,
    input logic             reset,
    rx_lane_deskew_if.slave bus
);
    localparam int CW = (MAX_SKEW > 2) ? $clog2(MAX_SKEW) : 1;
    localparam int HD = MAX_SKEW - 1;
    localparam logic [8:0]    COM  = {1'b1, COM_SYMBOL};
    localparam logic [CW-1:0] LAST = CW'(MAX_SKEW - 1);

    typedef enum logic {SEARCH, ALIGNED} state_t;

    state_t             r_state;
    logic [8:0]         r_hist [LANES][HD];
    logic [LANES-1:0]   r_seen;
    logic [CW-1:0]      r_stamp [LANES];
    logic [CW-1:0]      r_delay [LANES];
    logic [CW-1:0]      r_skewCnt;
    logic               r_win;
    logic [4:0]         r_numPrev;
    logic               r_numVld;
    logic [LANES*8-1:0] r_data;
    logic [LANES-1:0]   r_dataK;
    logic               r_valid;
    logic               r_locked;
    logic               r_error;

    logic [4:0]       w_n;
    logic [LANES-1:0] w_active;
    logic [LANES-1:0] w_com;
    logic [LANES-1:0] w_seenNext;
    logic [LANES-1:0] w_tcom;
    logic [8:0]       w_cur [LANES];
    logic [8:0]       w_tap [LANES];
    logic [CW-1:0]    w_stampNext [LANES];
    logic [CW-1:0]    w_cnt;
    logic             w_valid;
    logic             w_allSeen;
    logic             w_mismatch;
    logic             w_change;

    always_comb begin
        w_n = bus.numberOfDetectedLanes;
        if (w_n == 5'd0 || int'(w_n) > LANES) begin
            w_n = 5'(LANES);
        end
        // skew count this cycle: 0 when the cycle opens a window
        w_cnt = r_win ? r_skewCnt + 1'b1 : '0;
        for (int i = 0; i < LANES; i++) begin
            w_active[i] = (i < int'(w_n));
            w_cur[i]    = {bus.descramblerDataK[i],
                           bus.descramblerData[8*i +: 8]};
        end
        w_valid = &(bus.descramblerDataValid | ~w_active);
        for (int i = 0; i < LANES; i++) begin
            w_com[i]       = w_active[i] && w_valid && (w_cur[i] == COM);
            w_seenNext[i]  = r_seen[i] | w_com[i];
            w_stampNext[i] = (w_com[i] && !r_seen[i]) ? w_cnt : r_stamp[i];
            // tap 0 is the live input, tap k is history[k-1]
            w_tap[i] = w_cur[i];
            for (int k = 0; k < HD; k++) begin
                if (int'(r_delay[i]) == k + 1) begin
                    w_tap[i] = r_hist[i][k];
                end
            end
            w_tcom[i] = w_active[i] && (w_tap[i] == COM);
        end
        w_allSeen  = &(w_seenNext | ~w_active);
        w_mismatch = (|w_tcom) && !(&(w_tcom | ~w_active));
        w_change   = r_numVld &&
                     (bus.numberOfDetectedLanes != r_numPrev);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_seen    <= '0;
            r_skewCnt <= '0;
            r_win     <= 1'b0;
            r_numPrev <= '0;
            r_numVld  <= 1'b0;
            r_data    <= '0;
            r_dataK   <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_error   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_stamp[i] <= '0;
                r_delay[i] <= '0;
                for (int k = 0; k < HD; k++) begin
                    r_hist[i][k] <= '0;
                end
            end
        end else begin
            r_numVld  <= 1'b1;
            r_numPrev <= bus.numberOfDetectedLanes;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_data    <= '0;
            r_dataK   <= '0;
            if (w_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    r_hist[i][0] <= w_cur[i];
                    for (int k = 1; k < HD; k++) begin
                        r_hist[i][k] <= r_hist[i][k-1];
                    end
                end
            end
            // a lane-count change outranks overflow/mismatch and is silent
            if (w_change ||
                (r_state == ALIGNED && w_valid && w_mismatch)) begin
                r_error   <= !w_change;
                r_state   <= SEARCH;
                r_locked  <= 1'b0;
                r_win     <= 1'b0;
                r_seen    <= '0;
                r_skewCnt <= '0;
                for (int i = 0; i < LANES; i++) begin
                    r_stamp[i] <= '0;
                    r_delay[i] <= '0;
                    for (int k = 0; k < HD; k++) begin
                        r_hist[i][k] <= '0;
                    end
                end
            end else begin
                unique case (r_state)
                    SEARCH: begin
                        if (w_valid && (r_win || (|w_com))) begin
                            if (w_allSeen) begin
                                r_state   <= ALIGNED;
                                r_locked  <= 1'b1;
                                r_win     <= 1'b0;
                                r_seen    <= '0;
                                r_skewCnt <= '0;
                                for (int i = 0; i < LANES; i++) begin
                                    r_delay[i] <= w_active[i] ?
                                        w_cnt - w_stampNext[i] : '0;
                                end
                            end else if (w_cnt == LAST) begin
                                r_error   <= 1'b1;
                                r_win     <= 1'b0;
                                r_seen    <= '0;
                                r_skewCnt <= '0;
                            end else begin
                                r_win     <= 1'b1;
                                r_skewCnt <= w_cnt;
                                r_seen    <= w_seenNext;
                                for (int i = 0; i < LANES; i++) begin
                                    r_stamp[i] <= w_stampNext[i];
                                end
                            end
                        end
                    end
                    ALIGNED: begin
                        if (w_valid) begin
                            r_valid <= 1'b1;
                            for (int i = 0; i < LANES; i++) begin
                                if (w_active[i]) begin
                                    r_data[8*i +: 8] <= w_tap[i][7:0];
                                    r_dataK[i]       <= w_tap[i][8];
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign bus.deskewData   = r_data;
    assign bus.deskewDataK  = r_dataK;
    assign bus.deskewValid  = r_valid;
    assign bus.deskewLocked = r_locked;
    assign bus.deskewError  = r_error;
endmodule

// File: tb/tb_rx_lane_deskew.sv
// Directed testbench for rx_lane_deskew (LANES=16, MAX_SKEW=4).
// Drives columns after posedge+1, samples outputs one unit after the edge.
module tb_rx_lane_deskew;
    logic clk;
    logic reset;
    logic [7:0]  sd [16];
    logic        sk [16];
    logic [15:0] sv;
    int total;
    int bad;

    rx_lane_deskew_if #(.LANES(16)) bus();

    rx_lane_deskew #(
        .LANES(16),
        .MAX_SKEW(4),
        .COM_SYMBOL(8'hBC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bo(int l, int p);
        return 8'((l << 6) | p);
    endfunction

    function automatic logic [8:0] stream(int l, int p);
        if (p == -1 || p == 7) return 9'h1BC;
        if (p < -1) return 9'h0EE;
        return {1'b0, bo(l, p)};
    endfunction

    task automatic apply();
        logic [127:0] d;
        logic [15:0]  k;
        for (int i = 0; i < 16; i++) begin
            d[8*i +: 8] = sd[i];
            k[i] = sk[i];
        end
        bus.descramblerData      = d;
        bus.descramblerDataK     = k;
        bus.descramblerDataValid = sv;
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 16; i++) begin
            sd[i] = 8'h00;
            sk[i] = 1'b0;
        end
        sv = 16'hFFFF;
    endtask

    task automatic set_com(int l);
        sd[l] = 8'hBC;
        sk[l] = 1'b1;
    endtask

    task automatic set_dat(int l, logic [7:0] d);
        sd[l] = d;
        sk[l] = 1'b0;
    endtask

    task automatic do_reset(logic [4:0] n);
        reset = 1'b0;
        bus.numberOfDetectedLanes = n;
        clear_lanes();
        apply();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.numberOfDetectedLanes = 5'd4;
        clear_lanes();
        apply();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.deskewData !== '0) begin
            $display("FAIL rst_data got=%h exp=0", bus.deskewData);
            bad++;
        end
        total++;
        if (bus.deskewDataK !== '0) begin
            $display("FAIL rst_k got=%h exp=0", bus.deskewDataK);
            bad++;
        end
        total++;
        if (bus.deskewValid !== 1'b0) begin
            $display("FAIL rst_valid got=%b exp=0", bus.deskewValid);
            bad++;
        end
        total++;
        if (bus.deskewLocked !== 1'b0) begin
            $display("FAIL rst_locked got=%b exp=0", bus.deskewLocked);
            bad++;
        end
        total++;
        if (bus.deskewError !== 1'b0) begin
            $display("FAIL rst_error got=%b exp=0", bus.deskewError);
            bad++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        total++;
        if (bus.deskewLocked !== 1'b0) begin
            $display("FAIL rst_idle_lock got=%b exp=0", bus.deskewLocked);
            bad++;
        end
    endtask

    task automatic test_aligned_lock();
        logic [127:0] ed;
        do_reset(5'd4);
        for (int l = 0; l < 4; l++) set_com(l);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL al_locked got=%b exp=1", bus.deskewLocked);
            bad++;
        end
        total++;
        if (bus.deskewValid !== 1'b0) begin
            $display("FAIL al_comcol got=%b exp=0", bus.deskewValid);
            bad++;
        end
        for (int l = 0; l < 4; l++) set_dat(l, 8'(8'h10 + l));
        step();
        ed = '0;
        ed[31:0] = 32'h13121110;
        total++;
        if (bus.deskewValid !== 1'b1) begin
            $display("FAIL al_valid got=%b exp=1", bus.deskewValid);
            bad++;
        end
        total++;
        if (bus.deskewData !== ed || bus.deskewDataK !== '0) begin
            $display("FAIL al_data got=%h/%h exp=%h/0",
                     bus.deskewData, bus.deskewDataK, ed);
            bad++;
        end
    endtask

    task automatic test_skew();
        logic [127:0] ed;
        logic [15:0]  ek;
        logic [8:0]   e9;
        do_reset(5'd4);
        for (int c = 0; c < 14; c++) begin
            for (int l = 0; l < 4; l++) begin
                {sk[l], sd[l]} = stream(l, c - ((l == 2) ? 3 : 1));
            end
            step();
            if (c == 1) begin
                total++;
                if (bus.deskewLocked !== 1'b0) begin
                    $display("FAIL sk_early_lock got=%b exp=0",
                             bus.deskewLocked);
                    bad++;
                end
            end
            if (c == 2) begin
                total++;
                if (bus.deskewLocked !== 1'b1) begin
                    $display("FAIL sk_lock got=%b exp=1", bus.deskewLocked);
                    bad++;
                end
            end
            if (c >= 3) begin
                ed = '0;
                ek = '0;
                for (int l = 0; l < 4; l++) begin
                    e9 = stream(l, c - 3);
                    ed[8*l +: 8] = e9[7:0];
                    ek[l] = e9[8];
                end
                total++;
                if (bus.deskewValid !== 1'b1 || bus.deskewError !== 1'b0 ||
                    bus.deskewData !== ed || bus.deskewDataK !== ek) begin
                    $display("FAIL sk_col%0d got=%b%b %h/%h exp=10 %h/%h",
                             c, bus.deskewValid, bus.deskewError,
                             bus.deskewData, bus.deskewDataK, ed, ek);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [127:0] ed;
        do_reset(5'd2);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_com(0);
            else set_dat(0, 8'(c));
            set_dat(1, 8'(8'h30 + c));
            step();
            total++;
            if (bus.deskewError !== (c == 3) ||
                bus.deskewLocked !== 1'b0) begin
                $display("FAIL ov_c%0d got=err%b lock%b exp=err%0d lock0",
                         c, bus.deskewError, bus.deskewLocked, c == 3);
                bad++;
            end
        end
        set_dat(0, 8'h05);
        set_com(1);
        step();
        total++;
        if (bus.deskewError !== 1'b0 || bus.deskewLocked !== 1'b0) begin
            $display("FAIL ov_restart got=err%b lock%b exp=err0 lock0",
                     bus.deskewError, bus.deskewLocked);
            bad++;
        end
        set_com(0);
        set_dat(1, 8'h51);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL ov_relock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
        set_dat(0, 8'h61);
        set_dat(1, 8'h52);
        step();
        ed = '0;
        ed[15:0] = 16'h5161;
        total++;
        if (bus.deskewValid !== 1'b1 || bus.deskewData !== ed) begin
            $display("FAIL ov_data got=%b %h exp=1 %h",
                     bus.deskewValid, bus.deskewData, ed);
            bad++;
        end
    endtask

    task automatic test_loss();
        logic [127:0] ed;
        do_reset(5'd2);
        set_com(0);
        set_com(1);
        step();
        set_dat(0, 8'h21);
        set_dat(1, 8'h22);
        step();
        total++;
        if (bus.deskewValid !== 1'b1 || bus.deskewLocked !== 1'b1) begin
            $display("FAIL ls_pre got=v%b l%b exp=v1 l1",
                     bus.deskewValid, bus.deskewLocked);
            bad++;
        end
        set_com(0);
        set_dat(1, 8'h23);
        step();
        total++;
        if (bus.deskewError !== 1'b1 || bus.deskewLocked !== 1'b0 ||
            bus.deskewValid !== 1'b0) begin
            $display("FAIL ls_hit got=e%b l%b v%b exp=e1 l0 v0",
                     bus.deskewError, bus.deskewLocked, bus.deskewValid);
            bad++;
        end
        set_dat(0, 8'h24);
        set_dat(1, 8'h25);
        step();
        total++;
        if (bus.deskewError !== 1'b0 || bus.deskewLocked !== 1'b0) begin
            $display("FAIL ls_after got=e%b l%b exp=e0 l0",
                     bus.deskewError, bus.deskewLocked);
            bad++;
        end
        set_com(0);
        set_com(1);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL ls_relock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
        set_dat(0, 8'h31);
        set_dat(1, 8'h32);
        step();
        ed = '0;
        ed[15:0] = 16'h3231;
        total++;
        if (bus.deskewValid !== 1'b1 || bus.deskewData !== ed) begin
            $display("FAIL ls_data got=%b %h exp=1 %h",
                     bus.deskewValid, bus.deskewData, ed);
            bad++;
        end
    endtask

    task automatic test_valid_gap();
        logic [127:0] ed;
        do_reset(5'd2);
        set_com(0);
        set_dat(1, 8'hEE);
        step();
        set_dat(0, bo(0, 0));
        set_com(1);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL vg_lock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
        for (int v = 2; v < 6; v++) begin
            if (v == 4) begin
                for (int g = 0; g < 2; g++) begin
                    sv[1] = 1'b0;
                    set_dat(0, bo(0, v - 1));
                    set_com(1);
                    step();
                    total++;
                    if (bus.deskewValid !== 1'b0 ||
                        bus.deskewError !== 1'b0 ||
                        bus.deskewLocked !== 1'b1) begin
                        $display("FAIL vg_gap%0d got=v%b e%b l%b exp=v0 e0 l1",
                                 g, bus.deskewValid, bus.deskewError,
                                 bus.deskewLocked);
                        bad++;
                    end
                end
                sv[1] = 1'b1;
            end
            set_dat(0, bo(0, v - 1));
            set_dat(1, bo(1, v - 2));
            step();
            ed = '0;
            ed[15:0] = {bo(1, v - 2), bo(0, v - 2)};
            total++;
            if (bus.deskewValid !== 1'b1 || bus.deskewData !== ed) begin
                $display("FAIL vg_v%0d got=%b %h exp=1 %h",
                         v, bus.deskewValid, bus.deskewData, ed);
                bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.deskewData !== '0 || bus.deskewDataK !== '0 ||
            bus.deskewValid !== 1'b0 || bus.deskewLocked !== 1'b0 ||
            bus.deskewError !== 1'b0) begin
            $display("FAIL rm_clear got=%h %h v%b l%b e%b exp=all 0",
                     bus.deskewData, bus.deskewDataK, bus.deskewValid,
                     bus.deskewLocked, bus.deskewError);
            bad++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_dat(0, 8'h11);
            set_dat(1, 8'h12);
            step();
            total++;
            if (bus.deskewLocked !== 1'b0) begin
                $display("FAIL rm_nolock%0d got=%b exp=0",
                         c, bus.deskewLocked);
                bad++;
            end
        end
        set_com(0);
        set_com(1);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL rm_relock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
    endtask

    task automatic test_lane_change();
        do_reset(5'd4);
        for (int l = 0; l < 4; l++) set_com(l);
        step();
        for (int l = 0; l < 4; l++) set_dat(l, 8'(8'h40 + l));
        step();
        total++;
        if (bus.deskewLocked !== 1'b1 || bus.deskewValid !== 1'b1) begin
            $display("FAIL lc_pre got=l%b v%b exp=l1 v1",
                     bus.deskewLocked, bus.deskewValid);
            bad++;
        end
        bus.numberOfDetectedLanes = 5'd2;
        set_com(0);
        for (int l = 1; l < 4; l++) set_dat(l, 8'(8'h50 + l));
        step();
        total++;
        if (bus.deskewLocked !== 1'b0 || bus.deskewError !== 1'b0 ||
            bus.deskewValid !== 1'b0) begin
            $display("FAIL lc_change got=l%b e%b v%b exp=l0 e0 v0",
                     bus.deskewLocked, bus.deskewError, bus.deskewValid);
            bad++;
        end
        for (int l = 0; l < 4; l++) set_dat(l, 8'(8'h60 + l));
        step();
        total++;
        if (bus.deskewError !== 1'b0 || bus.deskewLocked !== 1'b0) begin
            $display("FAIL lc_after got=e%b l%b exp=e0 l0",
                     bus.deskewError, bus.deskewLocked);
            bad++;
        end
        set_com(0);
        set_com(1);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL lc_relock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
    endtask

    task automatic test_single_lane();
        logic [127:0] ed;
        do_reset(5'd1);
        set_com(0);
        set_dat(1, 8'h99);
        step();
        total++;
        if (bus.deskewLocked !== 1'b1) begin
            $display("FAIL sl_lock got=%b exp=1", bus.deskewLocked);
            bad++;
        end
        set_dat(0, 8'h5A);
        set_com(1);
        sv[1] = 1'b0;
        step();
        ed = '0;
        ed[7:0] = 8'h5A;
        total++;
        if (bus.deskewValid !== 1'b1 || bus.deskewData !== ed ||
            bus.deskewDataK !== '0) begin
            $display("FAIL sl_data got=%b %h/%h exp=1 %h/0",
                     bus.deskewValid, bus.deskewData, bus.deskewDataK, ed);
            bad++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_aligned_lock();
        test_skew();
        test_overflow();
        test_loss();
        test_valid_gap();
        test_reset_mid();
        test_lane_change();
        test_single_lane();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
